// File: rtl/pile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pile_pkg
// Brief   : Shared types and constants for the brick-pile auto driver.
// Revision: 1.0 - initial release
// ============================================================================
package pile_pkg;

  // Default width of the target and height feedback buses
  localparam int W_DEFAULT = 3;

  // Driver sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_PRESS   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } pile_state_t;

  // Button selected for the current step
  localparam logic DIR_PLUS  = 1'b1;
  localparam logic DIR_MOINS = 1'b0;

  // True while a run is in progress (busy window)
  function automatic logic is_active(input pile_state_t s);
    return (s == ST_COMPARE) || (s == ST_PRESS) || (s == ST_RELEASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pile_step_timer.sv
`default_nettype none
// ============================================================================
// Module  : pile_step_timer
// Brief   : Loadable down-counter that times the press and release phases.
//           o_last marks the final cycle of a loaded phase.
// Revision: 1.0 - initial release
// ============================================================================
module pile_step_timer
  import pile_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero,
  output logic             o_last
);

  logic [WIDTH-1:0] r_count;

  // Load on request, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);
  assign o_last = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/pile_driver.sv
`default_nettype none
// ============================================================================
// Module  : pile_driver
// Brief   : Drives the pile's plus/moins buttons with timed press/release
//           steps until the height feedback matches a latched target.
//           Optional macro PILE_DRIVER_SHORTEST_PATH_EN selects direction by
//           modular distance so moves may cross the wrap boundary.
// Revision: 1.0 - initial release
// ============================================================================
module pile_driver
  import pile_pkg::*;
#(
  parameter int W              = W_DEFAULT,
  parameter int PRESS_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 2,
  parameter int MAX_STEPS      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] target,
  input  logic [W-1:0] hauteur,
  output logic         plus,
  output logic         moins,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int TMAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(MAX_STEPS + 1);

  pile_state_t   r_state;
  pile_state_t   w_next;
  logic [W-1:0]  r_target;
  logic [SW-1:0] r_steps;
  logic          r_dir;
  logic          w_dir;
  logic          w_dir_eff;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_value;
  logic          w_tmr_zero;
  logic          w_tmr_last;
  logic          w_phase_end;

  pile_step_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_zero  (w_tmr_zero),
    .o_last  (w_tmr_last)
  );

  // A phase ends on its final counted cycle; a zero count never stalls
  assign w_phase_end = w_tmr_last | w_tmr_zero;

`ifdef PILE_DRIVER_SHORTEST_PATH_EN
  logic [W-1:0] w_diff;
  // Modular distance upward; ties at half the ring go upward
  always_comb begin
    w_diff = r_target - hauteur;
    w_dir  = (w_diff <= W'(1 << (W - 1))) ? DIR_PLUS : DIR_MOINS;
  end
`else
  // Plain unsigned compare, never crossing the wrap boundary
  always_comb begin
    w_dir = (r_target > hauteur) ? DIR_PLUS : DIR_MOINS;
  end
`endif

  // Direction is decided in COMPARE and held for the rest of the step
  assign w_dir_eff = (r_state == ST_COMPARE) ? w_dir : r_dir;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and timer control; abort overrides everything outside IDLE
  always_comb begin
    w_next      = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (hauteur == r_target) begin
          w_next = ST_DONE;
        end else if (r_steps == SW'(MAX_STEPS)) begin
          w_next = ST_ERROR;
        end else begin
          w_next      = ST_PRESS;
          w_tmr_load  = 1'b1;
          w_tmr_value = TW'(PRESS_CYCLES);
        end
      end
      ST_PRESS: begin
        if (w_phase_end) begin
          w_next      = ST_RELEASE;
          w_tmr_load  = 1'b1;
          w_tmr_value = TW'(RELEASE_CYCLES);
        end
      end
      ST_RELEASE: begin
        if (w_phase_end) w_next = ST_COMPARE;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) w_next = ST_ERROR;
  end

  // Target latch, saturating step count and direction hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_target <= '0;
      r_steps  <= '0;
      r_dir    <= DIR_PLUS;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_target <= target;
        r_steps  <= '0;
      end
      if (r_state == ST_COMPARE) begin
        r_dir <= w_dir;
      end
      if ((r_state == ST_RELEASE) && (w_next == ST_COMPARE) && (r_steps != SW'(MAX_STEPS))) begin
        r_steps <= r_steps + SW'(1);
      end
    end
  end

  // Outputs registered from the next state so they line up with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      plus  <= 1'b0;
      moins <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      plus  <= (w_next == ST_PRESS) && (w_dir_eff == DIR_PLUS);
      moins <= (w_next == ST_PRESS) && (w_dir_eff == DIR_MOINS);
      busy  <= is_active(w_next);
      done  <= (w_next == ST_DONE);
      error <= (w_next == ST_ERROR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pile_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_pile_driver
// Brief   : Directed bench for pile_driver with a small pile model that
//           steps its height on each button rising edge.
//           Honours PILE_DRIVER_SHORTEST_PATH_EN for the wrap test.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pile_driver;

  localparam int W              = 3;
  localparam int PRESS_CYCLES   = 2;
  localparam int RELEASE_CYCLES = 2;
  localparam int MAX_STEPS      = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [W-1:0] target;
  logic [W-1:0] pile;
  logic         plus, moins, busy, done, error;

  logic         pile_load;
  logic [W-1:0] pile_init;
  logic         frozen;
  logic         plus_q = 1'b0;
  logic         moins_q = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int m_end, m_done, m_err, m_plus, m_moins, m_badlen, m_badgap, m_both, m_busy;

  pile_driver #(
    .W              (W),
    .PRESS_CYCLES   (PRESS_CYCLES),
    .RELEASE_CYCLES (RELEASE_CYCLES),
    .MAX_STEPS      (MAX_STEPS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .target  (target),
    .hauteur (pile),
    .plus    (plus),
    .moins   (moins),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Pile model: one height step per button rising edge, wraps modulo 2^W
  always @(posedge clk) begin
    plus_q  <= plus;
    moins_q <= moins;
    if (pile_load) begin
      pile <= pile_init;
    end else if (!frozen) begin
      if (plus && !plus_q)        pile <= pile + 3'd1;
      else if (moins && !moins_q) pile <= pile - 3'd1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic load_pile(input logic [W-1:0] val, input logic frz);
    @(negedge clk);
    pile_init = val;
    pile_load = 1'b1;
    frozen    = frz;
    @(negedge clk);
    pile_load = 1'b0;
  endtask

  // Start is sampled on the next rising edge (edge k)
  task automatic do_start(input logic [W-1:0] tgt);
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
  endtask

  // Observe cycle n=1.. (n=1 is the cycle after edge k) until done/error or max_n
  task automatic run_mon(input int max_n, input int abort_at, input int start_at);
    int  n, plen, mlen, low;
    bit  had;
    n = 0; plen = 0; mlen = 0; low = 0; had = 1'b0;
    m_end = 0; m_done = 0; m_err = 0; m_plus = 0; m_moins = 0;
    m_badlen = 0; m_badgap = 0; m_both = 0; m_busy = 0;
    while ((n < max_n) && (m_end == 0)) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      abort = 1'b0;
      if (plus && moins) m_both++;
      if (busy) m_busy++;
      if (plus || moins) begin
        if ((plus && plen == 0) || (moins && mlen == 0)) begin
          if (had && low < RELEASE_CYCLES) m_badgap++;
          had = 1'b1;
        end
        low = 0;
      end else begin
        low++;
      end
      if (plus) plen++;
      else if (plen > 0) begin
        m_plus++;
        if (plen != PRESS_CYCLES) m_badlen++;
        plen = 0;
      end
      if (moins) mlen++;
      else if (mlen > 0) begin
        m_moins++;
        if (mlen != PRESS_CYCLES) m_badlen++;
        mlen = 0;
      end
      if (done || error) begin
        m_end  = n;
        m_done = int'(done);
        m_err  = int'(error);
      end else begin
        if (n == abort_at) abort = 1'b1;
        if (n == start_at) begin
          start  = 1'b1;
          target = 3'd7;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; target = '0;
    pile_init = '0; pile_load = 1'b1; frozen = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", int'({plus, moins, busy, done, error}), 0);
    pile_load = 1'b0;
    reset = 1'b0;

    // Equal height: done two cycles after start, one busy cycle, no presses
    load_pile(3'd3, 1'b1);
    do_start(3'd3);
    run_mon(120, 0, 0);
    check("eq_latency", m_end, 2);
    check("eq_done", m_done, 1);
    check("eq_plus", m_plus, 0);
    check("eq_moins", m_moins, 0);
    check("eq_busy_cycles", m_busy, 1);
    @(negedge clk);
    check("eq_done_pulse", int'(done), 0);

    // 1 -> 4 upward: three presses, done after 17 cycles
    load_pile(3'd1, 1'b0);
    do_start(3'd4);
    run_mon(120, 0, 0);
    check("up_latency", m_end, 17);
    check("up_done", m_done, 1);
    check("up_plus", m_plus, 3);
    check("up_moins", m_moins, 0);
    check("up_len", m_badlen, 0);
    check("up_gap", m_badgap, 0);
    check("up_both", m_both, 0);
    check("up_height", int'(pile), 4);

    // 6 -> 1: downward by default, across the wrap with shortest path
    load_pile(3'd6, 1'b0);
    do_start(3'd1);
    run_mon(120, 0, 0);
`ifdef PILE_DRIVER_SHORTEST_PATH_EN
    check("wrap_latency", m_end, 17);
    check("wrap_plus", m_plus, 3);
    check("wrap_moins", m_moins, 0);
`else
    check("down_latency", m_end, 27);
    check("down_moins", m_moins, 5);
    check("down_plus", m_plus, 0);
`endif
    check("wd_len", m_badlen, 0);
    check("wd_height", int'(pile), 1);

    // Frozen height: MAX_STEPS presses then timeout
    load_pile(3'd0, 1'b1);
    do_start(3'd5);
    run_mon(120, 0, 0);
    check("to_latency", m_end, 82);
    check("to_error", m_err, 1);
    check("to_done", m_done, 0);
    check("to_plus", m_plus, 16);
    @(negedge clk);
    check("to_busy_after", int'(busy), 0);

    // Abort in 2nd press cycle of step 2; stray start mid-run is ignored
    load_pile(3'd0, 1'b0);
    do_start(3'd5);
    run_mon(120, 8, 4);
    check("ab_latency", m_end, 9);
    check("ab_error", m_err, 1);
    check("ab_plus", m_plus, 2);
    check("ab_btn_low", int'(plus), 0);
    repeat (3) @(negedge clk);
    check("ab_idle", int'({busy, plus, moins, done, error}), 0);

    // Reset in the first release cycle, then a clean run to 2
    load_pile(3'd0, 1'b0);
    do_start(3'd5);
    run_mon(4, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_outs", int'({plus, moins, busy, done, error}), 0);
    reset = 1'b0;
    check("rst_height", int'(pile), 1);
    do_start(3'd2);
    run_mon(120, 0, 0);
    check("rr_latency", m_end, 7);
    check("rr_done", m_done, 1);
    check("rr_plus", m_plus, 1);
    check("rr_height", int'(pile), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
